exc_csr_ctrl: RTL and testbench
===============================

Name: exc_csr_ctrl

Overview:
- Trap/flush controller and minimal CSR file for the 5-stage LoongArch pipeline.
- Consumes the writeback stage's exception/ertn report, updates CRMD/PRMD/ESTAT/ERA and flushes all stages.
- Sequences a held redirect to the fetch stage and serves CSR read/write from the execute stage.
- Owns the stable timer and interrupt-pending detection, and returns has_int to decode for INT tagging.

Parameters:
- TIMER_W, 32, width of TCFG.InitVal+2 and TVAL.
- HWI_N, 8, number of hardware interrupt lines (ESTAT.IS[9:2]).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wb_ex  in  1  WB exception commit (already qualified by WB valid).
- wb_ecode  in  6  exception code.
- wb_esubcode  in  9  exception subcode.
- wb_pc  in  32  PC of the faulting instruction.
- ertn_flush  in  1  WB ertn commit.
- csr_re  in  1  CSR read request.
- csr_num  in  14  CSR address.
- csr_rvalue  out  32  read data, combinational from csr_num.
- csr_we  in  1  CSR write enable.
- csr_wmask  in  32  bit write mask.
- csr_wvalue  in  32  write data.
- hw_int_in  in  HWI_N  level hardware interrupts.
- has_int  out  1  interrupt pending and enabled.
- flush  out  1  kill all pipeline stages.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts redirect.

Behaviour:
- Reset (clk edge with reset=1): all CSRs cleared (CRMD.PLV=0, IE=0), timer disabled, TVAL=0, FSM=IDLE. redirect_valid=0, redirect_pc=0. flush and has_int are 0 while inputs are idle.
- flush = wb_ex | ertn_flush, combinational, same cycle.
- Trap (wb_ex=1): PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE; CRMD.PLV<=0, CRMD.IE<=0; ESTAT.Ecode[21:16]<=wb_ecode, EsubCode[30:22]<=wb_esubcode; ERA<=wb_pc. Captured target = EENTRY (pre-edge value, low 6 bits zero).
- ertn (ertn_flush=1, wb_ex=0): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE. Captured target = ERA. If wb_ex and ertn_flush are both 1, the trap wins and ertn is ignored.
- FSM IDLE: a trap or ertn moves to REDIR; redirect_pc<=target; redirect_valid=1 from the next cycle.
- FSM REDIR: redirect_valid and redirect_pc are held stable until redirect_ready=1, then return to IDLE (redirect_valid=0 next cycle).
  - A new trap/ertn arriving in REDIR applies its CSR updates, overwrites redirect_pc and stays in REDIR, even if redirect_ready is high that cycle.
- CSR write: new = (old & ~wmask) | (wvalue & wmask), restricted to writable fields.
  - CRMD[2:0]; PRMD[2:0]; ECFG.LIE[12:0] excluding bit 10; ESTAT.IS[1:0] only; ERA[31:0]; EENTRY[31:6]; TCFG[TIMER_W-1:0].
  - TICLR bit0=1 clears IS[11]; TICLR reads 0.
  - On the same cycle, a trap/ertn update wins over a CSR write for the fields it touches.
- CSR read: unknown csr_num returns 0 and writes to it are ignored. Reads return pre-edge values, with no bypass of a same-cycle write.
- ESTAT.IS[9:2] <= hw_int_in every cycle (one-cycle registered).
- Timer:
  - A TCFG write with En=1 loads TVAL <= {InitVal,2'b00} and enables counting; a write with En=0 stops it.
  - Each enabled cycle TVAL decrements.
  - When TVAL==0 and enabled: IS[11]<=1. If Periodic, reload {InitVal,2'b00}; otherwise TVAL<=all-ones and the timer stops.
  - TI set and TICLR on the same cycle: set wins.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
- Reset mid-REDIR: FSM returns to IDLE and redirect_valid drops the next cycle.

Decomposition:
- Shared package `loongarch_csr_pkg`:
  - CSR numbers: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, TCFG 0x41, TVAL 0x42, TICLR 0x44.
  - ECODE constants: INT 0x00, ADE 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D, TLBR 0x3F.
  - Field bit positions.
- One sub-module `csr_timer`: owns TCFG/TVAL and the TI set pulse, with inputs for the write strobe and TICLR.

Test Plan:
- EENTRY=0x1C008000, CRMD.IE=1, PLV=3; wb_ex=1, ecode=0x0B, pc=0x1C000100:
  - flush=1 the same cycle.
  - Next cycle redirect_valid=1, pc=0x1C008000.
  - ERA=0x1C000100, ESTAT[21:16]=0x0B, PRMD=0x7, CRMD[2:0]=0.
- Continuing: hold redirect_ready=0 for 3 cycles -> redirect_valid/pc stable. ready=1 -> valid=0 next cycle. ertn_flush=1 -> CRMD[2:0]=0x7, redirect_pc=0x1C000100.
- TCFG write 0x0000000B (InitVal=2, En, Periodic):
  - TVAL counts 8..0.
  - IS[11]=1 the cycle after 0 is reached, then TVAL=8 again.
  - TICLR write 1 clears IS[11].
- ECFG.LIE[11]=1, CRMD.IE=1, timer fires -> has_int=1. CRMD.IE=0 -> has_int=0.
- Same-cycle csr_we to CRMD (wvalue 0x3, mask 0x7) and wb_ex -> CRMD[2:0]=0 (trap wins); read of csr_num 0x99 -> 0.
- wb_ex in REDIR with new EENTRY=0x1C00A000 -> redirect_pc updates to 0x1C00A000, still valid. Reset asserted -> redirect_valid=0 next cycle.

Source files
------------

// File: rtl/loongarch_csr_pkg.sv
// Shared CSR numbering, exception codes and field positions
// for the LoongArch trap/flush controller.
package loongarch_csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int CRMD_IE      = 2;
    localparam int ESTAT_TI     = 11;
    localparam int ESTAT_EC_LSB = 16;
    localparam int ESTAT_ES_LSB = 22;
    localparam int EENTRY_LSB   = 6;
    localparam int TCFG_EN      = 0;
    localparam int TCFG_PERIOD  = 1;
    localparam int TCFG_INIT    = 2;

    // LIE bit 10 is reserved and never writable
    localparam logic [12:0] LIE_WMASK = 13'h1BFF;

    typedef enum logic {
        ST_IDLE,
        ST_REDIR
    } redir_state_t;

endpackage

// File: rtl/exc_csr_timer.sv
// Stable timer: TCFG/TVAL registers and the timer interrupt bit.
// Module name kept as csr_timer; file groups with the top.
module csr_timer
    import loongarch_csr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wmask,
    input  logic [TIMER_W-1:0] tcfg_wvalue,
    input  logic               ticlr,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               ti
);

    logic               en;
    logic               ti_set;
    logic [TIMER_W-1:0] tcfg_new;
    logic [TIMER_W-1:0] reload_cur;
    logic [TIMER_W-1:0] reload_new;

    assign tcfg_new   = (tcfg & ~tcfg_wmask) | (tcfg_wvalue & tcfg_wmask);
    assign reload_cur = {tcfg[TIMER_W-1:TCFG_INIT], 2'b00};
    assign reload_new = {tcfg_new[TIMER_W-1:TCFG_INIT], 2'b00};
    assign ti_set     = en & (tval == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg <= '0;
            tval <= '0;
            en   <= 1'b0;
            ti   <= 1'b0;
        end else begin
            if (tcfg_we) begin
                tcfg <= tcfg_new;
                en   <= tcfg_new[TCFG_EN];
                if (tcfg_new[TCFG_EN])
                    tval <= reload_new;
            end else if (en) begin
                if (tval == '0) begin
                    if (tcfg[TCFG_PERIOD]) begin
                        tval <= reload_cur;
                    end else begin
                        tval <= '1;
                        en   <= 1'b0;
                    end
                end else begin
                    tval <= tval - TIMER_W'(1);
                end
            end
            // a timer expiry in the same cycle as TICLR keeps TI set
            if (ti_set)
                ti <= 1'b1;
            else if (ticlr)
                ti <= 1'b0;
        end
    end

endmodule

// File: rtl/exc_csr_ctrl.sv
// Trap/ertn controller, minimal CSR file and held fetch redirect
// for the 5-stage LoongArch pipeline.
module exc_csr_ctrl
    import loongarch_csr_pkg::*;
#(
    parameter int TIMER_W = 32,
    parameter int HWI_N   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_ex,
    input  logic [5:0]       wb_ecode,
    input  logic [8:0]       wb_esubcode,
    input  logic [31:0]      wb_pc,
    input  logic             ertn_flush,
    input  logic             csr_re,
    input  logic [13:0]      csr_num,
    output logic [31:0]      csr_rvalue,
    input  logic             csr_we,
    input  logic [31:0]      csr_wmask,
    input  logic [31:0]      csr_wvalue,
    input  logic [HWI_N-1:0] hw_int_in,
    output logic             has_int,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready
);

    logic [2:0]         crmd;
    logic [2:0]         prmd;
    logic [12:0]        lie;
    logic [1:0]         is_sw;
    logic [HWI_N-1:0]   is_hw;
    logic [5:0]         ecode;
    logic [8:0]         esubcode;
    logic [31:0]        era;
    logic [25:0]        eentry;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;
    logic               ti;

    logic [31:0] estat;
    logic [12:0] is_all;
    logic [31:0] rdata;
    logic [31:0] target;
    logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat;
    logic        wr_era, wr_eentry, wr_tcfg, ticlr;
    logic [12:0] lie_m;

    redir_state_t state, state_nx;
    logic [31:0]  pc_nx;

    assign wr_crmd   = csr_we & (csr_num == CSR_CRMD);
    assign wr_prmd   = csr_we & (csr_num == CSR_PRMD);
    assign wr_ecfg   = csr_we & (csr_num == CSR_ECFG);
    assign wr_estat  = csr_we & (csr_num == CSR_ESTAT);
    assign wr_era    = csr_we & (csr_num == CSR_ERA);
    assign wr_eentry = csr_we & (csr_num == CSR_EENTRY);
    assign wr_tcfg   = csr_we & (csr_num == CSR_TCFG);
    assign ticlr     = csr_we & (csr_num == CSR_TICLR)
                     & csr_wmask[0] & csr_wvalue[0];
    assign lie_m     = csr_wmask[12:0] & LIE_WMASK;

    assign is_all = {1'b0, ti, 1'b0, 8'(is_hw), is_sw};
    assign estat  = {1'b0, esubcode, ecode, 3'b000, is_all};

    assign flush   = wb_ex | ertn_flush;
    assign has_int = crmd[CRMD_IE] & (|(is_all & lie));
    assign target  = wb_ex ? {eentry, 6'b0} : era;

    csr_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we    (wr_tcfg),
        .tcfg_wmask (csr_wmask[TIMER_W-1:0]),
        .tcfg_wvalue(csr_wvalue[TIMER_W-1:0]),
        .ticlr      (ticlr),
        .tcfg       (tcfg),
        .tval       (tval),
        .ti         (ti)
    );

    // trap/ertn updates come last so they override a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd     <= '0;
            prmd     <= '0;
            lie      <= '0;
            is_sw    <= '0;
            is_hw    <= '0;
            ecode    <= '0;
            esubcode <= '0;
            era      <= '0;
            eentry   <= '0;
        end else begin
            is_hw <= hw_int_in;
            if (wr_crmd)
                crmd <= (crmd & ~csr_wmask[2:0])
                      | (csr_wvalue[2:0] & csr_wmask[2:0]);
            if (wr_prmd)
                prmd <= (prmd & ~csr_wmask[2:0])
                      | (csr_wvalue[2:0] & csr_wmask[2:0]);
            if (wr_ecfg)
                lie <= (lie & ~lie_m) | (csr_wvalue[12:0] & lie_m);
            if (wr_estat)
                is_sw <= (is_sw & ~csr_wmask[1:0])
                       | (csr_wvalue[1:0] & csr_wmask[1:0]);
            if (wr_era)
                era <= (era & ~csr_wmask) | (csr_wvalue & csr_wmask);
            if (wr_eentry)
                eentry <= (eentry & ~csr_wmask[31:EENTRY_LSB])
                        | (csr_wvalue[31:EENTRY_LSB]
                           & csr_wmask[31:EENTRY_LSB]);
            if (wb_ex) begin
                prmd     <= crmd;
                crmd     <= 3'b000;
                ecode    <= wb_ecode;
                esubcode <= wb_esubcode;
                era      <= wb_pc;
            end else if (ertn_flush) begin
                crmd <= prmd;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (csr_num)
            CSR_CRMD:   rdata = {29'd0, crmd};
            CSR_PRMD:   rdata = {29'd0, prmd};
            CSR_ECFG:   rdata = {19'd0, lie};
            CSR_ESTAT:  rdata = estat;
            CSR_ERA:    rdata = era;
            CSR_EENTRY: rdata = {eentry, 6'b0};
            CSR_TCFG:   rdata = 32'(tcfg);
            CSR_TVAL:   rdata = 32'(tval);
            default:    rdata = '0;
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            redirect_pc <= '0;
        end else begin
            state       <= state_nx;
            redirect_pc <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = redirect_pc;
        unique case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_nx = ST_REDIR;
                    pc_nx    = target;
                end
            end
            ST_REDIR: begin
                if (flush)
                    pc_nx = target;
                else if (redirect_ready)
                    state_nx = ST_IDLE;
            end
        endcase
    end

    assign redirect_valid = (state == ST_REDIR);

endmodule

// File: tb/tb_exc_csr_ctrl.sv
// Directed checks of trap/ertn sequencing, CSR access and timer.
module tb_exc_csr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [7:0]  hw_int_in;
    logic        has_int;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_cmp = 0;
    int n_bad = 0;

    exc_csr_ctrl #(.TIMER_W(32), .HWI_N(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_ex         (wb_ex),
        .wb_ecode      (wb_ecode),
        .wb_esubcode   (wb_esubcode),
        .wb_pc         (wb_pc),
        .ertn_flush    (ertn_flush),
        .csr_re        (csr_re),
        .csr_num       (csr_num),
        .csr_rvalue    (csr_rvalue),
        .csr_we        (csr_we),
        .csr_wmask     (csr_wmask),
        .csr_wvalue    (csr_wvalue),
        .hw_int_in     (hw_int_in),
        .has_int       (has_int),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_csr(input string tag, input logic [13:0] num,
                           input logic [31:0] exp);
        logic [31:0] v;
        csr_re  = 1'b1;
        csr_num = num;
        #1;
        v = csr_rvalue;
        csr_re  = 1'b0;
        chk(tag, v, exp);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask,
                      input logic [31:0] val);
        csr_we     = 1'b1;
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0;
        wb_pc = '0; ertn_flush = 1'b0; csr_re = 1'b0; csr_num = '0;
        csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        hw_int_in = '0; redirect_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(redirect_valid), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_has_int", 32'(has_int), 32'd0);
        chk_csr("rst_crmd", 14'h000, 32'd0);

        wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8000);
        wr(14'h000, 32'h7, 32'h7);
        chk_csr("crmd_w", 14'h000, 32'h7);
        chk_csr("eentry_w", 14'h00C, 32'h1C00_8000);

        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0100;
        #1;
        chk("trap_flush", 32'(flush), 32'd1);
        tick();
        wb_ex = 1'b0;
        chk("trap_valid", 32'(redirect_valid), 32'd1);
        chk("trap_pc", redirect_pc, 32'h1C00_8000);
        chk_csr("trap_era", 14'h006, 32'h1C00_0100);
        chk_csr("trap_estat", 14'h005, 32'h000B_0000);
        chk_csr("trap_prmd", 14'h001, 32'h7);
        chk_csr("trap_crmd", 14'h000, 32'h0);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(redirect_valid), 32'd1);
            chk("hold_pc", redirect_pc, 32'h1C00_8000);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("ack_valid", 32'(redirect_valid), 32'd0);

        ertn_flush = 1'b1;
        #1;
        chk("ertn_flush", 32'(flush), 32'd1);
        tick();
        ertn_flush = 1'b0;
        chk_csr("ertn_crmd", 14'h000, 32'h7);
        chk("ertn_valid", 32'(redirect_valid), 32'd1);
        chk("ertn_pc", redirect_pc, 32'h1C00_0100);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        wr(14'h004, 32'h1FFF, 32'h0800);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
        chk_csr("tval_load", 14'h042, 32'd8);
        chk("pre_int", 32'(has_int), 32'd0);
        for (int k = 7; k >= 0; k--) begin
            tick();
            chk_csr("tval_cnt", 14'h042, 32'(k));
        end
        tick();
        chk_csr("tval_reload", 14'h042, 32'd8);
        chk_csr("ti_set", 14'h005, 32'h000B_0800);
        chk("timer_int", 32'(has_int), 32'd1);
        wr(14'h000, 32'h4, 32'h0);
        chk("ie_off_int", 32'(has_int), 32'd0);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        chk_csr("ticlr", 14'h005, 32'h000B_0000);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0);

        wr(14'h000, 32'h7, 32'h3);
        csr_we = 1'b1; csr_num = 14'h000;
        csr_wmask = 32'h7; csr_wvalue = 32'h3;
        wb_ex = 1'b1; wb_ecode = 6'h08; wb_pc = 32'h1C00_0200;
        tick();
        csr_we = 1'b0; wb_ex = 1'b0;
        chk_csr("trap_wins", 14'h000, 32'h0);
        chk_csr("trap_prmd2", 14'h001, 32'h3);
        chk("trap2_pc", redirect_pc, 32'h1C00_8000);
        chk_csr("unknown_rd", 14'h099, 32'h0);

        wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_A000);
        chk("redir_keep", redirect_pc, 32'h1C00_8000);
        wb_ex = 1'b1; wb_ecode = 6'h0C; wb_pc = 32'h1C00_0300;
        redirect_ready = 1'b1;
        tick();
        wb_ex = 1'b0; redirect_ready = 1'b0;
        chk("retrap_valid", 32'(redirect_valid), 32'd1);
        chk("retrap_pc", redirect_pc, 32'h1C00_A000);
        chk_csr("retrap_era", 14'h006, 32'h1C00_0300);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(redirect_valid), 32'd0);
        chk("mid_rst_pc", redirect_pc, 32'd0);
        chk_csr("mid_rst_era", 14'h006, 32'd0);

        hw_int_in = 8'h05;
        tick();
        chk_csr("hw_is", 14'h005, 32'h0000_0014);
        wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_csr("lie_mask", 14'h004, 32'h0000_1BFF);
        chk_csr("ticlr_rd", 14'h044, 32'h0);
        wr(14'h099, 32'hFFFF_FFFF, 32'h1234_5678);
        chk_csr("unknown_wr", 14'h099, 32'h0);
        chk("ie0_int", 32'(has_int), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
